// File: rtl/dsp48a1_mac_pkg.sv
// Shared constants and state encoding for the DSP48A1 dot-product sequencer.
package dsp48a1_mac_pkg;

  // OPMODE values with the pre-adder off and carry-in 0: X in [1:0], Z in [3:2].
  localparam logic [7:0] OPM_LOAD = 8'h01;
  localparam logic [7:0] OPM_ACC  = 8'h09;
  localparam logic [7:0] OPM_HOLD = 8'h08;

  localparam int P_LAT_DEF    = 4;
  localparam int OPM_SKEW_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/dsp_opmode_dly.sv
// Fixed-depth OPMODE delay line that lines the opcode up with the slice's A/B/M pipeline.
module dsp_opmode_dly
  import dsp48a1_mac_pkg::*;
#(
  parameter int DEPTH = OPM_SKEW_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] opm_i,
  output logic [7:0] opm_o
);

  logic [7:0] line_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= OPM_HOLD;
    end else begin
      line_q[0] <= opm_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign opm_o = line_q[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Feeds signed operand pairs into a fully pipelined DSP48A1 and returns the
// dot product of each IN_LAST-delimited vector once the slice pipeline has drained.
module dsp48a1_mac_seq
  import dsp48a1_mac_pkg::*;
#(
  parameter int P_LAT    = P_LAT_DEF,
  parameter int OPM_SKEW = OPM_SKEW_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
  input  logic             IN_LAST,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [7:0]       DSP_OPMODE,
  input  logic [47:0]      DSP_P,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [47:0]      RES_DATA,
  output logic [CNT_W-1:0] RES_COUNT,
  output logic [1:0]       DBG_STATE
);

  localparam int DRN_W = $clog2(P_LAT + 1);

  state_e           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [17:0]      a_q, a_d, b_q, b_d;
  logic [47:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_valid_q, res_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept;
  logic [7:0]       opm_in;

  // Both streams transfer on a rising edge where valid and ready are high;
  // a source holds its data stable while valid is high and ready is low.
  assign accept = IN_VALID && in_ready_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_valid_d = res_valid_q;
    opm_in      = OPM_HOLD;

    if (accept) begin
      a_d = IN_A;
      b_d = IN_B;
      if (state_q == ST_IDLE) begin
        opm_in = OPM_LOAD;
        cnt_d  = CNT_W'(1);
      end else begin
        opm_in = OPM_ACC;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      if (IN_LAST) begin
        state_d = ST_DRAIN;
        drain_d = DRN_W'(P_LAT);
      end else begin
        state_d = ST_ACCUM;
      end
    end

    case (state_q)
      ST_DRAIN: begin
        if (drain_q == '0) begin
          res_data_d  = DSP_P;
          res_count_d = cnt_q;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Registered from the next state so IN_READY reads 0 while reset is held.
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  dsp_opmode_dly #(
    .DEPTH (OPM_SKEW)
  ) u_opm_dly (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .opm_i  (opm_in),
    .opm_o  (DSP_OPMODE)
  );

  assign IN_READY  = in_ready_q;
  assign DSP_A     = a_q;
  assign DSP_B     = b_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_COUNT = res_count_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Bench for dsp48a1_mac_seq wired to a behavioural DSP48A1 slice (all registers on).
module tb_dsp48a1_mac_seq;
  import dsp48a1_mac_pkg::*;

  localparam int P_LAT    = 4;
  localparam int OPM_SKEW = 3;
  localparam int CNT_W    = 16;

  // ---------------- clock / reset / signals ----------------
  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             IN_VALID = 1'b0;
  logic             IN_LAST = 1'b0;
  logic [17:0]      IN_A = '0;
  logic [17:0]      IN_B = '0;
  logic             IN_READY;
  logic [17:0]      DSP_A, DSP_B;
  logic [7:0]       DSP_OPMODE;
  logic [47:0]      DSP_P;
  logic             RES_VALID, RES_READY;
  logic [47:0]      RES_DATA;
  logic [CNT_W-1:0] RES_COUNT;
  logic [1:0]       DBG_STATE;

  int   rr_mode = 1;   // 0: hold RES_READY low, 1: high, 2: random
  logic rr_bit  = 1'b1;
  assign RES_READY = (rr_mode == 2) ? rr_bit : (rr_mode == 1);

  always #5 CLK = ~CLK;

  dsp48a1_mac_seq #(
    .P_LAT(P_LAT), .OPM_SKEW(OPM_SKEW), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_A(IN_A), .IN_B(IN_B), .IN_LAST(IN_LAST),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_OPMODE(DSP_OPMODE), .DSP_P(DSP_P),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_COUNT(RES_COUNT),
    .DBG_STATE(DBG_STATE)
  );

  // ---------------- DSP48A1 slice: A0/A1, B0/B1, M, P, OPMODE registers ----------------
  logic signed [17:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic signed [35:0] m_r = '0;
  logic [7:0]         opm_r = OPM_HOLD;
  logic [47:0]        p_r = 48'h5A5A_1234_BEEF;
  logic [47:0]        x_mux, z_mux;

  assign x_mux = (opm_r[1:0] == 2'b01) ? 48'(m_r) : 48'h0;
  assign z_mux = (opm_r[3:2] == 2'b10) ? p_r : 48'h0;
  assign DSP_P = p_r;

  always @(posedge CLK) begin
    a0    <= DSP_A;  a1 <= a0;
    b0    <= DSP_B;  b1 <= b0;
    m_r   <= a1 * b1;
    opm_r <= DSP_OPMODE;
    p_r   <= x_mux + z_mux;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [47:0]        exp_q[$];
  logic [CNT_W-1:0]   exp_cnt_q[$];
  logic signed [47:0] acc = '0;
  int                 n_el = 0;
  int                 cyc = 0;
  int                 last_acc_edge = 0;
  logic               prev_rv = 1'b0;
  logic               post_hs = 1'b0;
  logic [47:0]        last_data = '0;
  logic [CNT_W-1:0]   last_count = '0;

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      acc = '0; n_el = 0; prev_rv = 1'b0; post_hs = 1'b0;
    end else begin
      if (post_hs) begin
        check("res_valid_one_cycle", 64'(RES_VALID), 64'd0);
        check("in_ready_after_hs", 64'(IN_READY), 64'd1);
        post_hs = 1'b0;
      end
      if (RES_VALID && !prev_rv)
        check("res_latency", 64'(cyc - 1), 64'(last_acc_edge + P_LAT + 1));
      if (RES_VALID) begin
        check("in_ready_in_hold", 64'(IN_READY), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else if (RES_READY) begin
          check("res_data", 64'(RES_DATA), 64'(exp_q[0]));
          check("res_count", 64'(RES_COUNT), 64'(exp_cnt_q[0]));
          last_data  = RES_DATA;
          last_count = RES_COUNT;
          void'(exp_q.pop_front());
          void'(exp_cnt_q.pop_front());
          post_hs = 1'b1;
        end else begin
          check("res_data_stalled", 64'(RES_DATA), 64'(exp_q[0]));
        end
      end
      if (IN_VALID && IN_READY) begin
        acc = acc + $signed(IN_A) * $signed(IN_B);
        n_el++;
        last_acc_edge = cyc;
        if (IN_LAST) begin
          exp_q.push_back(acc);
          exp_cnt_q.push_back((n_el >= 2**CNT_W - 1) ? '1 : CNT_W'(n_el));
          acc  = '0;
          n_el = 0;
        end
      end
      prev_rv = RES_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  initial forever begin
    @(posedge CLK); #1;
    rr_bit = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 after the pair is taken and gap idle cycles.
  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last,
                           input int gap);
    int waited = 0;
    IN_A = a; IN_B = b; IN_LAST = last; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && waited < 200) begin
      waited++;
      @(negedge CLK);
    end
    if (waited >= 200) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_ref_vec(input int gap);
    send_pair(18'sd3, 18'sd4, 1'b0, gap);
    send_pair(18'sd5, 18'sd6, 1'b0, gap);
    send_pair(-18'sd2, 18'sd7, 1'b1, gap);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || RES_VALID) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge CLK); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(IN_READY),   64'd0);
    check({tag, "_res_valid"}, 64'(RES_VALID),  64'd0);
    check({tag, "_res_data"},  64'(RES_DATA),   64'd0);
    check({tag, "_res_count"}, 64'(RES_COUNT),  64'd0);
    check({tag, "_dsp_a"},     64'(DSP_A),      64'd0);
    check({tag, "_dsp_b"},     64'(DSP_B),      64'd0);
    check({tag, "_opmode"},    64'(DSP_OPMODE), 64'h08);
    check({tag, "_state"},     64'(DBG_STATE),  64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    @(posedge CLK); #1 RST_N = 1'b1;
    @(posedge CLK); #1;

    send_ref_vec(0);
    wait_done();
    check("b2b_data", 64'(last_data), 64'd28);
    check("b2b_count", 64'(last_count), 64'd3);

    send_ref_vec(2);
    wait_done();
    check("gap_data", 64'(last_data), 64'd28);
    check("gap_count", 64'(last_count), 64'd3);

    send_pair(18'sd1, 18'sd1, 1'b1, 0);
    wait_done();
    check("single_data", 64'(last_data), 64'd1);
    check("single_count", 64'(last_count), 64'd1);

    rr_mode = 0;
    send_ref_vec(0);
    t = 0;
    while (!RES_VALID && t < 50) begin @(negedge CLK); t++; end
    if (t >= 50) check("stall_valid_timeout", 64'd0, 64'd1);
    repeat (5) begin
      @(negedge CLK);
      check("stall_data", 64'(RES_DATA), 64'd28);
      check("stall_in_ready", 64'(IN_READY), 64'd0);
    end
    @(posedge CLK); #1 rr_mode = 1;
    wait_done();
    check("stall_count", 64'(last_count), 64'd3);

    send_pair(18'sd3, 18'sd4, 1'b0, 0);
    send_pair(18'sd5, 18'sd6, 1'b0, 0);
    @(negedge CLK); #2 RST_N = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge CLK);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    send_pair(18'sd2, 18'sd2, 1'b1, 0);
    wait_done();
    check("post_rst_data", 64'(last_data), 64'd4);
    check("post_rst_count", 64'(last_count), 64'd1);

    send_pair(18'h20000, 18'h20000, 1'b0, 0);
    send_pair(18'h20000, 18'h20000, 1'b1, 0);
    wait_done();
    check("min_sq_data", 64'(last_data), 64'h0008_0000_0000);
    send_pair(18'h20000, 18'h1FFFF, 1'b1, 0);
    wait_done();
    check("min_max_data", 64'(last_data), 64'hFFFC_0002_0000);

    rr_mode = 2;
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int e = 0; e < len; e++)
        send_pair(18'($urandom()), 18'($urandom()), e == len - 1, $urandom_range(0, 2));
    end
    wait_done();
    rr_mode = 1;
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
